cc_request_encoder: RTL

- Sequential counterpart of the N-to-2^N decoder: collects one-hot/multi-hot request strobes on REQ_WIDTH lines and emits them as binary indices, one per handshake.
- Pending requests are kept sticky; arbitration among them is round-robin.
- Sits between peripheral/event strobes (e.g. DuinoCube register-write or IRQ lines) and a consumer that services one indexed event at a time (MCU interface, sequencer).

---
 rtl/cc_request_encoder_pkg.sv | 11 +
 rtl/cc_rr_priority_encoder.sv | 31 +++
 rtl/cc_request_encoder.sv | 66 ++++++
 3 files changed

// File: rtl/cc_request_encoder_pkg.sv
// Shared helpers for the request encoder slice: index-width derivation.
package cc_request_encoder_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/cc_rr_priority_encoder.sv
// Round-robin priority encoder: first set bit of cand at or after rr_ptr, wrapping.
module cc_rr_priority_encoder
  import cc_request_encoder_pkg::*;
#(
  parameter int REQ_WIDTH = 8,
  parameter int IDX_WIDTH = 3
) (
  input  logic [REQ_WIDTH-1:0] cand,
  input  logic [IDX_WIDTH-1:0] rr_ptr,
  output logic [IDX_WIDTH-1:0] sel,
  output logic                 any
);

  logic [REQ_WIDTH-1:0]   mask;
  logic [2*REQ_WIDTH-1:0] dbl;

  // Lower half sees only lines at/after rr_ptr; upper half is the wrapped copy,
  // so the lowest set bit of dbl is the round-robin winner.
  always_comb begin
    mask = '0;
    for (int i = 0; i < REQ_WIDTH; i++)
      mask[i] = (i >= int'(rr_ptr));
    dbl = {cand, cand & mask};
    sel = '0;
    for (int i = 2*REQ_WIDTH-1; i >= 0; i--)
      if (dbl[i])
        sel = (i >= REQ_WIDTH) ? IDX_WIDTH'(i - REQ_WIDTH) : IDX_WIDTH'(i);
    any = |cand;
  end

endmodule

// File: rtl/cc_request_encoder.sv
// Sticky multi-hot request collector that emits one binary index per handshake,
// arbitrating pending lines round-robin.
module cc_request_encoder
  import cc_request_encoder_pkg::*;
#(
  parameter int REQ_WIDTH = 8,
  parameter int IDX_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [REQ_WIDTH-1:0] req,
  output logic [IDX_WIDTH-1:0] idx,
  output logic                 idx_valid,
  input  logic                 idx_ready,
  output logic [REQ_WIDTH-1:0] pending,
  output logic                 busy
);

  if (IDX_WIDTH != clog2(REQ_WIDTH) || REQ_WIDTH < 2) begin : g_bad_params
    $error("cc_request_encoder: IDX_WIDTH must equal clog2(REQ_WIDTH), REQ_WIDTH >= 2");
  end

  logic [REQ_WIDTH-1:0] cand;
  logic [IDX_WIDTH-1:0] rr_ptr;
  logic [IDX_WIDTH-1:0] sel;
  logic                 any;
  logic                 load;

  assign cand = pending | req;
  assign load = !idx_valid || idx_ready;
  assign busy = idx_valid || (|pending);

  cc_rr_priority_encoder #(
    .REQ_WIDTH (REQ_WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_prio (
    .cand   (cand),
    .rr_ptr (rr_ptr),
    .sel    (sel),
    .any    (any)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx       <= '0;
      idx_valid <= 1'b0;
      pending   <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      if (any) begin
        idx       <= sel;
        idx_valid <= 1'b1;
        // A same-cycle strobe on sel is absorbed by this grant.
        pending   <= cand & ~(REQ_WIDTH'(1) << sel);
        rr_ptr    <= (sel == IDX_WIDTH'(REQ_WIDTH-1)) ? '0 : sel + 1'b1;
      end else begin
        idx_valid <= 1'b0;
        pending   <= '0;
      end
    end else begin
      // Backpressure: idx stays stable, new strobes only accumulate.
      pending <= cand;
    end
  end

endmodule
